adma_ram_arbiter: RTL and testbench

ADMA_RAM_ARBITER -- requirements
Module: adma_ram_arbiter

---
 rtl/adma_ram_arbiter.sv | 149 ++++++++++++++
 tb/tb_adma_ram_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/adma_ram_arbiter.sv
// Two-port arbiter sharing one single-ported RAM between the ADMA engine (port 0)
// and the host (port 1). Grants are registered. Bursts are capped at MAX_BURST
// beats when the other port is waiting. Read returns are tagged with the issuing
// port and delivered RD_LATENCY cycles after the RAM read strobe.
module adma_ram_arbiter #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [1:0]    req,
  input  logic [1:0]    rd,
  input  logic [1:0]    wr,
  input  logic [127:0]  addr,
  input  logic [63:0]   wdata,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [31:0]   rdata,
  output logic [1:0]    collision,
  output logic [63:0]   ram_address,
  output logic          ram_read,
  output logic          ram_write,
  output logic [31:0]   data_to_ram,
  input  logic [31:0]   data_from_ram
);

  localparam int unsigned LastStage = RD_LATENCY - 1;
  localparam logic [7:0]  BurstLast = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StTurn} state_e;

  state_e                state_q, state_d;
  state_e                arb_state;
  logic                  last_owner_q, last_owner_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [1:0]            collision_q, collision_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0] pipe_port_q, pipe_port_d;

  logic owner_act;
  logic owner;
  logic other;
  logic beat;

  // Decode ownership and steer the owner's strobes, address and data to the RAM.
  always_comb begin
    owner_act   = (state_q == StOwn0) || (state_q == StOwn1);
    owner       = (state_q == StOwn1);
    other       = ~owner;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    ram_address = '0;
    data_to_ram = '0;
    if (owner_act) begin
      // A write wins over a simultaneous read; the read is dropped.
      ram_write   = wr[owner];
      ram_read    = rd[owner] & ~wr[owner];
      ram_address = owner ? addr[127:64] : addr[63:0];
      data_to_ram = owner ? wdata[63:32] : wdata[31:0];
    end
    beat = ram_read | ram_write;
  end

  // Arbitration shared by IDLE and TURN: sole requester wins, ties go to the
  // port that did not own last.
  always_comb begin
    arb_state = StIdle;
    case (req)
      2'b01:   arb_state = StOwn0;
      2'b10:   arb_state = StOwn1;
      2'b11:   arb_state = last_owner_q ? StOwn0 : StOwn1;
      default: arb_state = StIdle;
    endcase
  end

  // Ownership FSM next state, burst counting and last-owner tracking.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      StIdle, StTurn: begin
        state_d = arb_state;
        if (arb_state == StOwn0) begin
          last_owner_d = 1'b0;
          beat_cnt_d   = '0;
        end else if (arb_state == StOwn1) begin
          last_owner_d = 1'b1;
          beat_cnt_d   = '0;
        end
      end
      StOwn0, StOwn1: begin
        if (beat) beat_cnt_d = beat_cnt_q + 8'd1;
        if (!req[owner]) begin
          // Strobe in this cycle is still honoured above.
          state_d = StTurn;
        end else if (beat && (beat_cnt_q == BurstLast)) begin
          // Burst limit reached: hand over only if the other port is waiting.
          beat_cnt_d = '0;
          if (req[other]) state_d = StTurn;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read-return pipeline and collision flags for the next cycle.
  always_comb begin
    pipe_vld_d     = '0;
    pipe_port_d    = '0;
    pipe_vld_d[0]  = ram_read;
    pipe_port_d[0] = owner;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_port_d[i] = pipe_port_q[i-1];
    end
    collision_d = '0;
    if (owner_act && rd[owner] && wr[owner]) collision_d[owner] = 1'b1;
  end

  // State registers; reset also flushes reads in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      collision_q  <= '0;
      pipe_vld_q   <= '0;
      pipe_port_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      collision_q  <= collision_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_port_q  <= pipe_port_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    gnt    = {state_q == StOwn1, state_q == StOwn0};
    rvalid = '0;
    if (pipe_vld_q[LastStage]) rvalid[pipe_port_q[LastStage]] = 1'b1;
    collision = collision_q;
    rdata     = data_from_ram;
  end

endmodule

// File: tb/tb_adma_ram_arbiter.sv
// Scoreboard bench for adma_ram_arbiter: stimulus pushes per-cycle expectations from a
// behavioural model, a negedge monitor pops and compares them against the DUT.
module tb_adma_ram_arbiter;

  localparam int unsigned L   = 3;
  localparam int unsigned MAX = 16;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [1:0]    req = '0, rd = '0, wr = '0;
  logic [127:0]  addr = '0;
  logic [63:0]   wdata = '0;
  logic [1:0]    gnt, rvalid, collision;
  logic [31:0]   rdata, data_to_ram;
  logic [31:0]   data_from_ram = '0;
  logic [63:0]   ram_address;
  logic          ram_read, ram_write;

  adma_ram_arbiter #(.RD_LATENCY(L), .MAX_BURST(MAX)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .req(req), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .collision(collision),
    .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
    .data_to_ram(data_to_ram), .data_from_ram(data_from_ram)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  gnt, rvalid, collision;
    logic        rd_o, wr_o;
    logic [63:0] a;
    logic [31:0] d, rdat;
  } exp_t;
  typedef struct { int due; int port; } ret_t;

  exp_t exp_q[$];
  ret_t ret_q[$];
  int   checks = 0, errors = 0;

  // Model: own = -1 when nobody owns (idle or turnaround behave the same).
  int         own, last, beats, cyc;
  logic [1:0] col;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; last = 1; beats = 0; col = '0;
    ret_q.delete();
  endtask

  // Advance the model by one clock using the inputs held during the ending cycle.
  task automatic model_clock();
    int o;
    if (!RESET_N) begin
      model_reset();
    end else begin
      col = '0;
      if (own >= 0) begin
        o = own;
        if (rd[o] && wr[o]) col[o] = 1'b1;
        if (rd[o] && !wr[o]) ret_q.push_back('{due: cyc + L, port: o});
        if (!req[o]) own = -1;
        else if (rd[o] || wr[o]) begin
          beats++;
          if (beats == MAX) begin
            beats = 0;
            if (req[1-o]) own = -1;
          end
        end
      end else begin
        case (req)
          2'b01:   own = 0;
          2'b10:   own = 1;
          2'b11:   own = 1 - last;
          default: own = -1;
        endcase
        if (own >= 0) begin
          last = own; beats = 0;
        end
      end
      cyc++;
      while (ret_q.size() > 0 && ret_q[0].due < cyc) void'(ret_q.pop_front());
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e = '{gnt: '0, rvalid: '0, collision: '0, rd_o: 1'b0, wr_o: 1'b0, a: '0, d: '0, rdat: '0};
    if (own >= 0) begin
      e.gnt[own] = 1'b1;
      e.wr_o = wr[own];
      e.rd_o = rd[own] && !wr[own];
      e.a    = (own == 1) ? addr[127:64] : addr[63:0];
      e.d    = (own == 1) ? wdata[63:32] : wdata[31:0];
    end
    foreach (ret_q[k]) if (ret_q[k].due == cyc) e.rvalid[ret_q[k].port] = 1'b1;
    e.collision = col;
    e.rdat      = data_from_ram;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst_v, input logic [1:0] r, input logic [1:0] rdv,
                      input logic [1:0] wrv, input logic [127:0] a, input logic [63:0] w);
    @(posedge CLK);
    model_clock();
    #1;
    RESET_N = rst_v; req = r; rd = rdv; wr = wrv; addr = a; wdata = w;
    data_from_ram = $urandom;
    push_expect();
  endtask

  task automatic rstep(input logic rst_v, input logic [1:0] r, input logic [1:0] rdv,
                       input logic [1:0] wrv);
    step(rst_v, r, rdv, wrv, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
  endtask

  // Assert reset mid-cycle and check that outputs drop without waiting for a clock.
  task automatic reset_mid();
    #2;
    RESET_N = 1'b0;
    model_reset();
    void'(exp_q.pop_back());
    push_expect();
    #1;
    chk("async_rst_gnt", 64'(gnt), 64'd0);
    chk("async_rst_ram_read", 64'(ram_read), 64'd0);
    chk("async_rst_rvalid", 64'(rvalid), 64'd0);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("gnt", 64'(gnt), 64'(e.gnt));
        chk("rvalid", 64'(rvalid), 64'(e.rvalid));
        chk("collision", 64'(collision), 64'(e.collision));
        chk("ram_read", 64'(ram_read), 64'(e.rd_o));
        chk("ram_write", 64'(ram_write), 64'(e.wr_o));
        chk("ram_address", ram_address, e.a);
        chk("data_to_ram", 64'(data_to_ram), 64'(e.d));
        chk("rdata", 64'(rdata), 64'(e.rdat));
      end
    end
  end

  initial begin
    logic [1:0] rr, rdv, wrv;
    cyc = 0;
    model_reset();
    repeat (3) rstep(1'b0, 2'b11, 2'b00, 2'b00);
    // Release with both requesting: port 0 first.
    rstep(1'b1, 2'b11, 2'b00, 2'b00);
    // Port 0 streams reads while port 1 waits: burst cap then handover.
    repeat (22) rstep(1'b1, 2'b11, 2'b01, 2'b00);
    // Port 1 alone writes long past the burst cap.
    repeat (44) rstep(1'b1, 2'b10, 2'b00, 2'b10);
    // Port 1 read+write collision at a fixed address.
    step(1'b1, 2'b10, 2'b10, 2'b10, {64'h100, 64'h0}, {32'hDEADBEEF, 32'h0});
    repeat (2) rstep(1'b1, 2'b10, 2'b00, 2'b00);
    // Hand to port 0, which reads once while dropping its request.
    repeat (2) rstep(1'b1, 2'b01, 2'b00, 2'b00);
    rstep(1'b1, 2'b10, 2'b01, 2'b00);
    repeat (6) rstep(1'b1, 2'b10, 2'b00, 2'b10);
    // Port 0 mid-burst with reads outstanding, then reset.
    repeat (3) rstep(1'b1, 2'b01, 2'b00, 2'b00);
    repeat (2) rstep(1'b1, 2'b01, 2'b01, 2'b00);
    reset_mid();
    repeat (2) rstep(1'b0, 2'b01, 2'b01, 2'b00);
    repeat (6) rstep(1'b1, 2'b01, 2'b00, 2'b00);
    // Randomised traffic with slowly changing requests.
    rr = 2'b11;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) rr = 2'($urandom_range(0, 3));
      rdv = 2'($urandom);
      wrv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rstep(1'b1, rr, rdv, wrv);
    end
    repeat (L + 2) rstep(1'b1, 2'b00, 2'b00, 2'b00);
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
